mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requesters onto one shared variable-latency memory port.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed data-memory priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;

  // A requester still holding req during its own completion cycle is not re-served.
  logic if_elig, dm_elig, pick_dm;
  assign if_elig = if_req & ~if_valid_q;
  assign dm_elig = dm_req & ~dm_valid_q;

`ifdef MEM_ARB_RR_EN
  logic last_dm_q, last_dm_d;

  assign pick_dm = dm_elig & (~if_elig | ~last_dm_q);

  always_comb begin
    last_dm_d = last_dm_q;
    if (state_q == IDLE && (dm_elig || if_elig)) last_dm_d = pick_dm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_dm_q <= 1'b0;
    else       last_dm_q <= last_dm_d;
  end
`else
  assign pick_dm = dm_elig;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_dm) begin
          state_d = BUSY_DM;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          be_d    = dm_be;
          we_d    = dm_we;
        end else if (if_elig) begin
          state_d = BUSY_IF;
          addr_d  = if_addr;
          wdata_d = '0;
          be_d    = '1;
          we_d    = 1'b0;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          if (!we_q) dm_rdata_d = mem_rdata;
          dm_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign grant     = state_q;
  assign stall     = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-requester transactions plus hand sequences
// for arbitration ties, stale-request masking, ack while idle and reset mid-transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [1:0]  grant;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .grant(grant)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int unsigned dly;
    logic [31:0] rdata;
    logic [1:0]  exp_grant;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vt[5];
  logic [31:0] exp_if_rd, exp_dm_rd;
  logic [1:0]  tie_grant[3];
  logic [31:0] tie_addr[3];

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 2, 32'h0050_0093, 2'b01, 1'b0, 4'hF, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 0, 32'hBAD0_BAD0, 2'b10, 1'b1, 4'h3, 32'hDEAD_BEEF};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h1111_2222, 4'hF, 1, 32'h1234_5678, 2'b10, 1'b0, 4'hF, 32'h1111_2222};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 2'b01, 1'b0, 4'hF, 32'h0};
    vt[4] = '{1'b1, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 4'hC, 3, 32'h7777_7777, 2'b10, 1'b1, 4'hC, 32'h0BAD_F00D};
    tie_grant[0] = 2'b10; tie_grant[1] = 2'b01; tie_grant[2] = 2'b10;
    tie_addr[0]  = 32'h80; tie_addr[1]  = 32'h40; tie_addr[2]  = 32'h80;

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_if_rd = '0; exp_dm_rd = '0;

    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_bus", {mem_addr | mem_wdata}, 32'd0);
    chk("rst_mem_be_we", {27'b0, mem_be, mem_we}, 32'd0);
    chk("rst_valids", {30'b0, if_valid, dm_valid}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;

    // Single-requester transactions from the table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vt[i].is_dm) begin
        dm_req = 1'b1; dm_we = vt[i].we; dm_addr = vt[i].addr;
        dm_wdata = vt[i].wdata; dm_be = vt[i].be;
      end else begin
        if_req = 1'b1; if_addr = vt[i].addr;
      end
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, 32'd1);
      chk($sformatf("v%0d_grant", i), {30'b0, grant}, {30'b0, vt[i].exp_grant});
      chk($sformatf("v%0d_addr", i), mem_addr, vt[i].addr);
      chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, vt[i].exp_we});
      chk($sformatf("v%0d_be", i), {28'b0, mem_be}, {28'b0, vt[i].exp_be});
      chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].exp_wdata);
      chk($sformatf("v%0d_stall_busy", i), {31'b0, stall}, 32'd1);
      if (vt[i].is_dm) begin
        dm_addr = ~vt[i].addr; dm_wdata = ~vt[i].wdata; dm_be = ~vt[i].be;
      end else begin
        if_addr = ~vt[i].addr;
      end
      for (int d = 0; d < int'(vt[i].dly); d++) begin
        @(negedge clk);
        chk($sformatf("v%0d_addr_hold", i), mem_addr, vt[i].addr);
        chk($sformatf("v%0d_valid_early", i), {30'b0, if_valid, dm_valid}, 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = vt[i].rdata;
      if (!vt[i].is_dm) exp_if_rd = vt[i].rdata;
      else if (!vt[i].we) exp_dm_rd = vt[i].rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      chk($sformatf("v%0d_if_valid", i), {31'b0, if_valid}, {31'b0, ~vt[i].is_dm});
      chk($sformatf("v%0d_dm_valid", i), {31'b0, dm_valid}, {31'b0, vt[i].is_dm});
      chk($sformatf("v%0d_if_rdata", i), if_rdata, exp_if_rd);
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata, exp_dm_rd);
      chk($sformatf("v%0d_grant_done", i), {30'b0, grant}, 32'd0);
      chk($sformatf("v%0d_stall_valid", i), {31'b0, stall}, 32'd0);
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid_pulse", i), {30'b0, if_valid, dm_valid}, 32'd0);
    end

    // Both requesting and held for three rounds: DM, IF, DM with one idle cycle between
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_be = 4'hF; dm_wdata = '0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk($sformatf("tie%0d_grant", r), {30'b0, grant}, {30'b0, tie_grant[r]});
      chk($sformatf("tie%0d_addr", r), mem_addr, tie_addr[r]);
      mem_ack = 1'b1; mem_rdata = 32'hA0 + r;
      if (r == 1) exp_if_rd = 32'hA0 + r;
      else        exp_dm_rd = 32'hA0 + r;
      @(negedge clk);
      mem_ack = 1'b0;
      chk($sformatf("tie%0d_gap", r), {30'b0, grant}, 32'd0);
      chk($sformatf("tie%0d_valids", r), {30'b0, if_valid, dm_valid},
          (r == 1) ? 32'd2 : 32'd1);
      chk($sformatf("tie%0d_rdata", r), (r == 1) ? if_rdata : dm_rdata,
          (r == 1) ? exp_if_rd : exp_dm_rd);
      if (r == 2) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("tie_end_grant", {30'b0, grant}, 32'd0);

    // Stale request held through the completion cycle must not cause a repeat fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("stale_first_addr", mem_addr, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stale_first_valid", {31'b0, if_valid}, 32'd1);
    @(negedge clk);
    chk("stale_no_dup_grant", {30'b0, grant}, 32'd0);
    chk("stale_no_dup_req", {31'b0, mem_req}, 32'd0);
    chk("stale_no_dup_valid", {31'b0, if_valid}, 32'd0);
    if_addr = 32'h14;
    @(negedge clk);
    chk("stale_second_grant", {30'b0, grant}, 32'd1);
    chk("stale_second_addr", mem_addr, 32'h14);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    if_req = 1'b0;
    exp_if_rd = 32'h2222_2222;
    chk("stale_second_valid", {31'b0, if_valid}, 32'd1);
    chk("stale_second_rdata", if_rdata, exp_if_rd);
    @(negedge clk);
    chk("stale_end_grant", {30'b0, grant}, 32'd0);

    // Ack with nobody granted is ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("idle_ack%0d_valids", k), {30'b0, if_valid, dm_valid}, 32'd0);
      chk($sformatf("idle_ack%0d_grant", k), {30'b0, grant}, 32'd0);
      chk($sformatf("idle_ack%0d_rdata", k), if_rdata, exp_if_rd);
    end
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset while a data read is outstanding; the late ack lands in IDLE
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF;
    @(negedge clk);
    chk("rmid_busy_grant", {30'b0, grant}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rmid_mem_req_async", {31'b0, mem_req}, 32'd0);
    chk("rmid_grant_async", {30'b0, grant}, 32'd0);
    chk("rmid_rdata_cleared", if_rdata | dm_rdata, 32'd0);
    chk("rmid_stall_inputs", {31'b0, stall}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    dm_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rmid_no_valid", {30'b0, if_valid, dm_valid}, 32'd0);
    chk("rmid_grant_idle", {30'b0, grant}, 32'd0);
    chk("rmid_dm_rdata", dm_rdata, 32'd0);
    chk("rmid_stall_low", {31'b0, stall}, 32'd0);
    @(negedge clk);
    chk("rmid_no_valid_late", {30'b0, if_valid, dm_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
